// File: rtl/psec6_spi_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : psec6_spi_ctrl_if
//  Description : Host SPI and channel readout signals of the PSEC6 SPI
//                controller, bundled as one interface.
//                master modport : the controller (drives MISO, BUSY and the
//                                 channel/configuration outputs)
//                slave modport  : host plus channels (drive CS_B, MOSI and
//                                 CNT_SER_IN)
//  Ports       : CS_B, MOSI, CNT_SER_IN[NUM_CH-1:0]          host/channel -> ctrl
//                MISO, BUSY, INST_START, INST_READOUT, MODE[1:0],
//                DISCRIMINATOR_POLARITY, TRIG_DELAY[4:0],
//                SELECT_REG[2:0], CH_SEL[2:0]                ctrl -> host/channel
//  Revision    : 1.0  initial release
// ============================================================================
interface psec6_spi_ctrl_if #(
    parameter int NUM_CH = 8
);
    logic              CS_B;
    logic              MOSI;
    logic [NUM_CH-1:0] CNT_SER_IN;
    logic              MISO;
    logic              BUSY;
    logic              INST_START;
    logic              INST_READOUT;
    logic [1:0]        MODE;
    logic              DISCRIMINATOR_POLARITY;
    logic [4:0]        TRIG_DELAY;
    logic [2:0]        SELECT_REG;
    logic [2:0]        CH_SEL;

    modport master (
        input  CS_B, MOSI, CNT_SER_IN,
        output MISO, BUSY, INST_START, INST_READOUT, MODE,
               DISCRIMINATOR_POLARITY, TRIG_DELAY, SELECT_REG, CH_SEL
    );

    modport slave (
        output CS_B, MOSI, CNT_SER_IN,
        input  MISO, BUSY, INST_START, INST_READOUT, MODE,
               DISCRIMINATOR_POLARITY, TRIG_DELAY, SELECT_REG, CH_SEL
    );
endinterface
`default_nettype wire

// File: rtl/psec6_spi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : psec6_spi_ctrl
//  Description : PSEC6 SPI command decoder and channel readout sequencer.
//                16-bit frames {opcode[3:0], payload[11:0]} are shifted in MSB
//                first while CS_B is low. Opcodes: 0x1 WRITE_CFG, 0x2 START,
//                0x3 READOUT (6 words of WORD_BITS bits from one channel),
//                0x4 CFG readback (only with PSEC6_SPI_CFG_READBACK_EN).
//  Ports       : SPI_CLK  - sole clock, rising edge
//                RSTB     - asynchronous active-low reset
//                bus      - psec6_spi_ctrl_if.master (host SPI, channel
//                           strobes, configuration outputs)
//  Macro       : PSEC6_SPI_CFG_READBACK_EN - enables opcode 0x4 readback
//  Revision    : 1.0  initial release
// ============================================================================
module psec6_spi_ctrl #(
    parameter int NUM_CH    = 8,
    parameter int WORD_BITS = 10
) (
    input  wire logic        SPI_CLK,
    input  wire logic        RSTB,
    psec6_spi_ctrl_if.master bus
);
    localparam int CW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [CW-1:0] c_last_bit = CW'(WORD_BITS - 1);
    localparam logic [2:0]    c_last_word = 3'd5;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
`ifdef PSEC6_SPI_CFG_READBACK_EN
    localparam logic [1:0] c_st_rdbk  = 2'd3;
`endif

    logic [1:0]    r_state;
    logic [4:0]    r_fcnt;
    logic [14:0]   r_shift;      // previous 15 bits; the 16th comes straight from MOSI
    logic          r_cmd_vld;
    logic [3:0]    r_op;
    logic [7:0]    r_pl;         // payload[7:0]; higher payload bits carry no meaning
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_sel;
    logic [2:0]    r_ch_sel;
    logic [1:0]    r_mode;
    logic          r_pol;
    logic [4:0]    r_trig;
    logic          r_start;
    logic          w_miso;
`ifdef PSEC6_SPI_CFG_READBACK_EN
    logic [7:0]    r_rb_shift;
    logic [2:0]    r_rb_cnt;
`endif

    // Frame receiver. Frames completing while a sequence is running are
    // received but never committed.
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_fcnt    <= 5'd0;
            r_shift   <= 15'd0;
            r_cmd_vld <= 1'b0;
            r_op      <= 4'd0;
            r_pl      <= 8'd0;
        end else begin
            r_cmd_vld <= 1'b0;
            if (bus.CS_B) begin
                r_fcnt  <= 5'd0;
                r_shift <= 15'd0;
            end else if (r_fcnt != 5'd16) begin
                r_shift <= {r_shift[13:0], bus.MOSI};
                r_fcnt  <= r_fcnt + 5'd1;
                if (r_fcnt == 5'd15 && r_state == c_st_idle) begin
                    r_cmd_vld <= 1'b1;
                    r_op      <= r_shift[14:11];
                    r_pl      <= {r_shift[6:0], bus.MOSI};
                end
            end
        end
    end

    // Command execution and readout sequencer; runs regardless of CS_B.
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= '0;
            r_sel     <= 3'd0;
            r_ch_sel  <= 3'd0;
            r_mode    <= 2'd0;
            r_pol     <= 1'b0;
            r_trig    <= 5'd0;
            r_start   <= 1'b0;
`ifdef PSEC6_SPI_CFG_READBACK_EN
            r_rb_shift <= 8'd0;
            r_rb_cnt   <= 3'd0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (r_cmd_vld) begin
                        case (r_op)
                            4'h1: begin
                                r_mode <= r_pl[1:0];
                                r_pol  <= r_pl[2];
                                r_trig <= r_pl[7:3];
                            end
                            4'h2: r_start <= 1'b1;
                            4'h3: begin
                                // Channel number is checked as a 4-bit field so
                                // that 8..15 is rejected instead of aliasing.
                                if (32'(r_pl[3:0]) < NUM_CH) begin
                                    r_ch_sel  <= r_pl[2:0];
                                    r_sel     <= 3'd0;
                                    r_bit_cnt <= '0;
                                    r_state   <= c_st_load;
                                end
                            end
`ifdef PSEC6_SPI_CFG_READBACK_EN
                            4'h4: begin
                                r_rb_shift <= {r_trig, r_pol, r_mode};
                                r_rb_cnt   <= 3'd0;
                                r_state    <= c_st_rdbk;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                c_st_load: begin
                    r_bit_cnt <= '0;
                    r_state   <= c_st_shift;
                end
                c_st_shift: begin
                    if (r_bit_cnt == c_last_bit) begin
                        r_bit_cnt <= '0;
                        if (r_sel < c_last_word) begin
                            r_sel   <= r_sel + 3'd1;
                            r_state <= c_st_load;
                        end else begin
                            r_sel   <= 3'd0;
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
`ifdef PSEC6_SPI_CFG_READBACK_EN
                c_st_rdbk: begin
                    r_rb_shift <= {r_rb_shift[6:0], 1'b0};
                    r_rb_cnt   <= r_rb_cnt + 3'd1;
                    if (r_rb_cnt == 3'd7) begin
                        r_state <= c_st_idle;
                    end
                end
`endif
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_comb begin
        w_miso = 1'b0;
        if (r_state == c_st_shift) begin
            w_miso = bus.CNT_SER_IN[r_ch_sel];
        end
`ifdef PSEC6_SPI_CFG_READBACK_EN
        if (r_state == c_st_rdbk) begin
            w_miso = r_rb_shift[7];
        end
`endif
    end

    assign bus.MISO                   = w_miso;
    assign bus.BUSY                   = (r_state != c_st_idle);
    assign bus.INST_START             = r_start;
    assign bus.INST_READOUT           = (r_state == c_st_load);
    assign bus.MODE                   = r_mode;
    assign bus.DISCRIMINATOR_POLARITY = r_pol;
    assign bus.TRIG_DELAY             = r_trig;
    assign bus.SELECT_REG             = r_sel;
    assign bus.CH_SEL                 = r_ch_sel;

endmodule
`default_nettype wire
